// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDUOp encodings, default latencies and FSM state type for the multiply/divide unit
// Imported by mdu, mdu_calc, the control unit and the hazard unit so every
// block agrees on the MDUOp encoding.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    // True for the four operations that occupy the unit for a busy period.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath producing the HI/LO result
// Ports:
//   i_a, i_b  operands (rs, rt)
//   i_op      MDUOp; only mult/multu/div/divu produce a non-zero result
//   o_hi      product[63:32] or remainder
//   o_lo      product[31:0] or quotient
//   o_div0    divide operation with a zero divisor
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_sdiv;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'b0, i_a} * {32'b0, i_b};

    // Signed division runs on magnitudes through the same unsigned divider.
    // Negating 0x80000000 yields 0x80000000 as an unsigned magnitude, so
    // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign w_sdiv  = (i_op == MDU_DIV);
    assign w_a_neg = w_sdiv & i_a[31];
    assign w_b_neg = w_sdiv & i_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;

    // A zero divisor is replaced by 1 so the divider never sees zero; the
    // result is discarded via o_div0 anyway.
    assign w_q_mag = w_a_mag / ((w_b_mag == 32'd0) ? 32'd1 : w_b_mag);
    assign w_r_mag = w_a_mag % ((w_b_mag == 32'd0) ? 32'd1 : w_b_mag);

    always_comb begin
        o_hi   = '0;
        o_lo   = '0;
        o_div0 = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_hi = w_sprod[63:32];
                o_lo = w_sprod[31:0];
            end
            MDU_MULTU: begin
                o_hi = w_uprod[63:32];
                o_lo = w_uprod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                o_lo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
                o_hi   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
                o_div0 = (i_b == 32'd0);
            end
            default: begin
                o_hi   = '0;
                o_lo   = '0;
                o_div0 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - EX-stage multiply/divide unit holding HI/LO with fixed multi-cycle latency
// Ports:
//   clk, reset   core clock, asynchronous active-low reset
//   A, B         forwarded rs / rt values
//   MDUOp        operation select (mdu_pkg encodings)
//   Start        one-cycle pulse when a mult/multu/div/divu is in EX
//   Busy         computation in flight
//   MDUOut       HI for mfhi, LO for mflo, else 0 (combinational)
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] MDUOut
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 4) ? 4 : $clog2(CNT_MAX + 1);

    mdu_state_t        r_state;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_pend_hi;
    logic [31:0]       r_pend_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic [31:0]       w_hi;
    logic [31:0]       w_lo;
    logic              w_div0;
    logic              w_is_mult;

    mdu_calc u_calc (
        .i_a    (A),
        .i_b    (B),
        .i_op   (MDUOp),
        .o_hi   (w_hi),
        .o_lo   (w_lo),
        .o_div0 (w_div0)
    );

    assign w_is_mult = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && is_md_op(MDUOp)) begin
                        // On divide-by-zero the pending pair captures the current
                        // HI/LO, so completion writes back unchanged values. HI/LO
                        // cannot move during RUN, so this copy stays valid.
                        r_pend_hi <= w_div0 ? r_hi : w_hi;
                        r_pend_lo <= w_div0 ? r_lo : w_lo;
                        r_cnt     <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (MDUOp == MDU_MTHI) begin
                        r_hi <= A;
                    end else if (MDUOp == MDU_MTLO) begin
                        r_lo <= A;
                    end
                end
                S_RUN: begin
                    // Start and mthi/mtlo are ignored here; the hazard unit keeps them out.
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Busy = r_busy;

    always_comb begin
        MDUOut = '0;
        case (MDUOp)
            MDU_MFHI: MDUOut = r_hi;
            MDU_MFLO: MDUOut = r_lo;
            default:  MDUOut = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic HI/LO model
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .MDUOut (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural effect of one mult/multu/div/divu on the model HI/LO.
    task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] up;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            4'd2: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            4'd3: begin
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4'd4: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic read_hilo(input string tag);
        MDUOp = 4'd5;
        #1;
        checks++;
        if (MDUOut !== m_hi) begin
            errors++;
            $display("FAIL %s_mfhi got %h exp %h", tag, MDUOut, m_hi);
        end
        MDUOp = 4'd6;
        #1;
        checks++;
        if (MDUOut !== m_lo) begin
            errors++;
            $display("FAIL %s_mflo got %h exp %h", tag, MDUOut, m_lo);
        end
        MDUOp = 4'd0;
    endtask

    // Called at a falling edge; returns at the first falling edge with Busy low,
    // so a following call exercises a back-to-back Start.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input string tag);
        int          n;
        int          exp_n;
        logic [31:0] old_hi;
        exp_n  = (op == 4'd1 || op == 4'd2) ? 5 : 10;
        old_hi = m_hi;
        Start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd5;
        #1;
        checks++;
        if (MDUOut !== old_hi) begin
            errors++;
            $display("FAIL %s_busy_mfhi got %h exp %h", tag, MDUOut, old_hi);
        end
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            if (poke) begin
                case (n)
                    2: begin Start = 1'b1; MDUOp = 4'd1; A = $urandom; B = $urandom; end
                    3: begin Start = 1'b0; MDUOp = 4'd7; A = $urandom; end
                    4: begin MDUOp = 4'd8; A = $urandom; end
                    5: MDUOp = 4'd0;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        Start = 1'b0;
        MDUOp = 4'd0;
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s_busy_len got %0d exp %0d", tag, n, exp_n);
        end
        model_exec(op, a, b);
        read_hilo(tag);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v, input string tag);
        MDUOp = op;
        A = v;
        @(negedge clk);
        if (op == 4'd7) m_hi = v;
        else m_lo = v;
        read_hilo(tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        Start = 1'b0;
        MDUOp = 4'd0;
        A = '0;
        B = '0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", Busy);
        end
        read_hilo("reset");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        do_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, "mult");
        do_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        move_to(4'd7, 32'h11, "mthi");
        move_to(4'd8, 32'h22, "mtlo");
        do_op(4'd4, 32'd7, 32'd0, 1'b0, "divu0");
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "divovf");
        do_op(4'd1, 32'd6, 32'hFFFFFFF9, 1'b0, "b2b");
    endtask

    task automatic test_ignored_start;
        for (int i = 0; i < 3; i++) begin
            Start = 1'b1;
            MDUOp = (i == 0) ? 4'd5 : ((i == 1) ? 4'd9 : 4'd0);
            A = $urandom;
            B = $urandom;
            @(negedge clk);
            Start = 1'b0;
            MDUOp = 4'd0;
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start_%0d got busy %b exp 0", i, Busy);
            end
        end
        read_hilo("ignored");
    endtask

    task automatic test_busy_ignores;
        do_op(4'd4, $urandom, 32'($urandom_range(1, 1000)), 1'b1, "poke_divu");
        do_op(4'd1, $urandom, $urandom, 1'b1, "poke_mult");
    endtask

    task automatic test_random;
        logic [3:0] op;
        for (int i = 0; i < 14; i++) begin
            op = 4'($urandom_range(1, 4));
            do_op(op, pick(), pick(), (i % 4) == 0, "rand");
        end
    endtask

    task automatic test_reset_mid_run;
        move_to(4'd7, 32'hA5A5A5A5, "pre_rst_hi");
        move_to(4'd8, 32'h5A5A5A5A, "pre_rst_lo");
        Start = 1'b1;
        MDUOp = 4'd1;
        A = 32'd3;
        B = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy got %b exp 0", Busy);
        end
        read_hilo("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_busy got %b exp 0", Busy);
        end
        read_hilo("rst_after");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignored_start;
        test_busy_ignores;
        test_random;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the pipelined MIPS core, sitting beside the ALU and taking the same forwarded rs/rt operands. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It services mfhi/mflo/mthi/mtlo. It raises a busy flag that the hazard unit uses to stall any HI/LO-class instruction in ID.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- MDUOp  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- Start  in  1  high for one cycle when a mult/multu/div/divu is in EX
- Busy  out  1  computation in flight
- MDUOut  out  32  HI when MDUOp=5, LO when MDUOp=6, else 0; combinational from current HI/LO

## Operation
- State: HI, LO (32 each), pending hi/lo result (32 each), down-counter cnt (4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES)), Busy.
- FSM: IDLE and RUN.
  - IDLE to RUN when Start=1 and MDUOp∈{1..4}. Result is computed from A/B sampled at that edge. cnt loads MULT_CYCLES or DIV_CYCLES. Busy is set.
  - RUN: cnt decrements every edge. At the edge where cnt=1, pending is written to HI/LO, Busy clears, and the FSM goes to IDLE.
- Start with MDUOp∉{1..4} is ignored.
- Arithmetic:
  - mult: signed 32×32 to 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32 to 64; HI=[63:32], LO=[31:0].
  - div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend.
  - divu: unsigned; same HI/LO placement.
- Divide by zero (B=0): the busy period runs normally. HI and LO are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- mthi/mtlo in IDLE: HI or LO ← A at the edge.
- mthi/mtlo while Busy: ignored. The hazard unit must prevent this case.
- Start while Busy: ignored, with no restart. The hazard unit must prevent this case.
- mfhi/mflo while Busy: return pre-operation HI/LO (no forwarding of pending). The hazard unit stalls these reads.

## Timing
- Reset values: HI=0, LO=0, pending=0, cnt=0, Busy=0, state IDLE, MDUOut=0 (MDUOp permitting).
- Start sampled at edge E0:
  - Busy=1 for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES), from after E0 through E_N.
  - HI/LO update at E_N, the same edge where Busy falls.
  - The first cycle with Busy=0 already shows the new HI/LO on MDUOut.
- Hazard contract: ID stalls when (Start | Busy) and the ID instruction is an MD-class instruction. The Start term covers the E0 cycle before Busy rises.
- Back-to-back: a new Start is accepted in the first cycle after Busy falls.
- Reset asserted mid-RUN: the operation is abandoned, HI/LO are cleared, and Busy drops asynchronously.
- mthi/mtlo take effect at the edge, so a read in the next cycle sees the new value.

## Structure
- Shared package mdu_pkg holds:
  - MDUOp encodings as localparams: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO.
  - Default latencies MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
- The control unit and hazard unit import the same package.
- One sub-module, mdu_calc: purely combinational A, B, op → {hi, lo, div0}. The top keeps the FSM, counter and registers.

## Test plan
- Reset then mult A=0xFFFFFFFF, B=2 (signed): Busy high exactly 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
- multu, same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=-7 (0xFFFFFFF9), B=2: Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu A=7, B=0 after mthi 0x11 and mtlo 0x22: Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Back-to-back Start on the first non-busy cycle is accepted.
- Start mult 3×4, then pull reset low on the 3rd busy cycle: Busy=0 and HI=LO=0 immediately; after release, mflo=0.
